// File: rtl/vmul_pkg.sv
// Shared types and helpers for the SEW-configurable SIMD multiplier.
package vmul_pkg;

  typedef enum logic [1:0] {
    SEW8,
    SEW16,
    SEW32,
    SEW_RSV
  } sew_e;

  typedef enum logic [1:0] {
    MUL,
    MULH,
    MULHU,
    MULHSU
  } mulop_e;

  localparam int LATENCY = 3;

  function automatic int elem_count(sew_e s);
    case (s)
      SEW8:    return 4;
      SEW16:   return 2;
      SEW32:   return 1;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/vec_mul_pipe_if.sv
// Operand/result handshake bundle for vec_mul_pipe.
interface vec_mul_pipe_if
  import vmul_pkg::*;
#(
  parameter int LANES = 2,
  parameter int TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  sew_e                 in_sew;
  mulop_e               in_op;
  logic [LANES*32-1:0]  in_vs2;
  logic [LANES*32-1:0]  in_vs1;
  logic [LANES*32-1:0]  in_vd;
  logic [LANES*4-1:0]   in_mask;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*32-1:0]  out_data;
  logic [TAG_W-1:0]     out_tag;
  logic                 out_err;

  modport master (
    output in_valid, in_sew, in_op, in_vs2, in_vs1,
    output in_vd, in_mask, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_sew, in_op, in_vs2, in_vs1,
    input  in_vd, in_mask, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );

endinterface

// File: rtl/vmul_lane.sv
// One 32-bit lane: registered 8x8 partial products, then per-SEW
// recombination and high/low half selection.
module vmul_lane
  import vmul_pkg::*;
(
  input  logic        clk,
  input  logic        en,
  input  sew_e        sew0,
  input  mulop_e      op0,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  sew_e        sew1,
  input  mulop_e      op1,
  output logic [31:0] res
);

  logic [3:0]         top;
  logic               a_sgn;
  logic               b_sgn;
  logic signed [8:0]  a9 [4];
  logic signed [8:0]  b9 [4];
  logic signed [17:0] pp_n [4][4];
  logic signed [17:0] pp [4][4];
  logic signed [63:0] p32;
  logic [31:0]        p16 [2];
  logic               hi;

  // Only the top byte of a signed element carries the sign.
  always_comb begin
    case (sew0)
      SEW8:    top = 4'b1111;
      SEW16:   top = 4'b1010;
      default: top = 4'b1000;
    endcase
    a_sgn = (op0 == MULH) || (op0 == MULHSU);
    b_sgn = (op0 == MULH);
    for (int j = 0; j < 4; j++) begin
      a9[j] = {a_sgn & top[j] & a[8*j+7], a[8*j +: 8]};
      b9[j] = {b_sgn & top[j] & b[8*j+7], b[8*j +: 8]};
    end
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++)
        pp_n[j][k] = 18'(a9[j]) * 18'(b9[k]);
  end

  always_ff @(posedge clk) begin
    if (en)
      pp <= pp_n;
  end

  always_comb begin
    p32 = '0;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++)
        p32 = p32 + (64'(pp[j][k]) <<< (8 * (j + k)));
    for (int h = 0; h < 2; h++) begin
      p16[h] = '0;
      for (int j = 0; j < 2; j++)
        for (int k = 0; k < 2; k++)
          p16[h] = p16[h]
                 + (32'(pp[2*h+j][2*h+k]) << (8 * (j + k)));
    end
    hi  = (op1 != MUL);
    res = '0;
    case (sew1)
      SEW8:
        for (int i = 0; i < 4; i++)
          res[8*i +: 8] = hi ? pp[i][i][15:8] : pp[i][i][7:0];
      SEW16:
        for (int h = 0; h < 2; h++)
          res[16*h +: 16] = hi ? p16[h][31:16] : p16[h][15:0];
      default:
        res = hi ? p32[63:32] : p32[31:0];
    endcase
  end

endmodule

// File: rtl/vec_mul_pipe.sv
// SIMD integer multiplier: operand regs, partial products, then
// recombine + mask merge into the output regs, with a global stall.
module vec_mul_pipe
  import vmul_pkg::*;
#(
  parameter int LANES = 2,
  parameter int TAG_W = 4
)(
  input logic          clk,
  input logic          reset,
  vec_mul_pipe_if.slave bus
);

  localparam int W  = LANES * 32;
  localparam int NB = LANES * 4;
  localparam int IW = $clog2(NB);

  typedef struct packed {
    sew_e             sew;
    mulop_e           op;
    logic [W-1:0]     vd;
    logic [NB-1:0]    mask;
    logic [TAG_W-1:0] tag;
  } ctl_t;

  logic          stall;
  logic          adv;
  logic          v0;
  logic          v1;
  ctl_t          c0;
  ctl_t          c1;
  logic [W-1:0]  vs2_q;
  logic [W-1:0]  vs1_q;
  logic [W-1:0]  res;
  logic [W-1:0]  merged;
  logic [IW-1:0] e;

  assign stall       = bus.out_valid && !bus.out_ready;
  assign adv         = !stall;
  assign bus.in_ready = adv;

  always_ff @(posedge clk) begin
    if (reset) begin
      v0            <= 1'b0;
      v1            <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_tag   <= '0;
      bus.out_err   <= 1'b0;
    end else if (adv) begin
      v0            <= bus.in_valid;
      v1            <= v0;
      bus.out_valid <= v1;
      if (v1) begin
        bus.out_data <= merged;
        bus.out_tag  <= c1.tag;
        bus.out_err  <= (c1.sew == SEW_RSV);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      c0 <= '{sew: bus.in_sew, op: bus.in_op, vd: bus.in_vd,
              mask: bus.in_mask, tag: bus.in_tag};
      vs2_q <= bus.in_vs2;
      vs1_q <= bus.in_vs1;
      c1    <= c0;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    vmul_lane u_lane (
      .clk  (clk),
      .en   (adv),
      .sew0 (c0.sew),
      .op0  (c0.op),
      .a    (vs2_q[32*l +: 32]),
      .b    (vs1_q[32*l +: 32]),
      .sew1 (c1.sew),
      .op1  (c1.op),
      .res  (res[32*l +: 32])
    );
  end

  // Byte-granular merge: each byte follows the mask bit of its element.
  always_comb begin
    merged = c1.vd;
    e      = '0;
    for (int b = 0; b < NB; b++) begin
      case (c1.sew)
        SEW8:    e = IW'(b);
        SEW16:   e = IW'(b >> 1);
        default: e = IW'(b >> 2);
      endcase
      if (c1.sew != SEW_RSV && c1.mask[e])
        merged[8*b +: 8] = res[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_vec_mul_pipe.sv
// Directed and randomized checks of vec_mul_pipe against a plain-arithmetic model.
module tb_vec_mul_pipe;
  import vmul_pkg::*;

  typedef struct {
    int          sew;
    int          op;
    logic [63:0] vs2;
    logic [63:0] vs1;
    logic [63:0] vd;
    logic [7:0]  mask;
    logic [3:0]  tag;
  } op_t;

  typedef struct {
    logic [63:0] d;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   tests;
  int   fails;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  vec_mul_pipe_if #(.LANES(2), .TAG_W(4)) bus ();

  vec_mul_pipe #(.LANES(2), .TAG_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input op_t o);
    exp_t        r;
    int          s;
    logic [63:0] fm, fa, fb, p, v;
    r.tag = o.tag;
    r.err = (o.sew == 3);
    r.d   = o.vd;
    if (o.sew != 3) begin
      s  = 8 << o.sew;
      fm = (64'd1 << s) - 64'd1;
      for (int i = 0; i < 64 / s; i++) begin
        fa = (o.vs2 >> (i * s)) & fm;
        fb = (o.vs1 >> (i * s)) & fm;
        if ((o.op == 1 || o.op == 3) && fa[s-1]) fa = fa | ~fm;
        if (o.op == 1 && fb[s-1]) fb = fb | ~fm;
        p = fa * fb;
        v = (o.op == 0) ? (p & fm) : ((p >> s) & fm);
        if (o.mask[i])
          r.d = (r.d & ~(fm << (i * s))) | (v << (i * s));
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0:       return 64'h8080_8080_8080_8080;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h7FFF_8000_7F80_0001;
      3:       return 64'h0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic op_t rand_op(input logic [3:0] tag);
    op_t o;
    o.sew  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
    o.op   = int'($urandom_range(0, 3));
    o.vs2  = pick();
    o.vs1  = pick();
    o.vd   = {$urandom, $urandom};
    o.mask = 8'($urandom);
    o.tag  = tag;
    return o;
  endfunction

  function automatic op_t mk(input int sew, input int op,
                             input logic [63:0] vs2, input logic [63:0] vs1,
                             input logic [63:0] vd, input logic [7:0] mask,
                             input logic [3:0] tag);
    op_t o;
    o.sew = sew; o.op = op; o.vs2 = vs2; o.vs1 = vs1;
    o.vd = vd; o.mask = mask; o.tag = tag;
    return o;
  endfunction

  task automatic drive(input op_t o);
    bus.in_valid = 1'b1;
    bus.in_sew   = sew_e'(2'(o.sew));
    bus.in_op    = mulop_e'(2'(o.op));
    bus.in_vs2   = o.vs2;
    bus.in_vs1   = o.vs1;
    bus.in_vd    = o.vd;
    bus.in_mask  = o.mask;
    bus.in_tag   = o.tag;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string nm, input logic [63:0] d,
                           input logic [3:0] tag, input logic err);
    check({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({nm, "_data"}, bus.out_data, d);
    check({nm, "_tag"}, 64'(bus.out_tag), 64'(tag));
    check({nm, "_err"}, 64'(bus.out_err), 64'(err));
  endtask

  // One op through an idle pipe: result must appear exactly 3 cycles later.
  task automatic single(input string nm, input op_t o,
                        input logic [63:0] d, input logic err);
    drive(o);
    bus.out_ready = 1'b1;
    #1;
    check({nm, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    check({nm, "_lat1"}, 64'(bus.out_valid), 64'd0);
    tick();
    check({nm, "_lat2"}, 64'(bus.out_valid), 64'd0);
    tick();
    check_out(nm, d, o.tag, err);
    tick();
  endtask

  task automatic stream(input int n, input int mode, input string nm);
    op_t  cur;
    exp_t e;
    bit   have;
    bit   acc;
    int   sent;
    int   cyc;
    have = 0; sent = 0; cyc = 0;
    exp_q.delete();
    while ((sent < n || exp_q.size() != 0) && cyc < 2000) begin
      if (!have && sent < n && (mode == 0 || $urandom_range(0, 3) != 0)) begin
        cur  = rand_op(4'(sent));
        have = 1;
      end
      if (have) drive(cur);
      else bus.in_valid = 1'b0;
      bus.out_ready = (mode == 0) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      #1;
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check({nm, "_extra"}, 64'(bus.out_valid), 64'd0);
        end else begin
          e = exp_q[0];
          check({nm, "_data"}, bus.out_data, e.d);
          check({nm, "_tag"}, 64'(bus.out_tag), 64'(e.tag));
          check({nm, "_err"}, 64'(bus.out_err), 64'(e.err));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      acc = have && (bus.in_ready === 1'b1);
      tick();
      if (acc) begin
        exp_q.push_back(model(cur));
        have = 0;
        sent++;
      end
      cyc++;
    end
    check({nm, "_sent"}, 64'(sent), 64'(n));
    check({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) begin
      check({nm, "_no_dup"}, 64'(bus.out_valid), 64'd0);
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    op_t o;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sew    = SEW8;
    bus.in_op     = MUL;
    bus.in_vs2    = '0;
    bus.in_vs1    = '0;
    bus.in_vd     = '0;
    bus.in_mask   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_data", bus.out_data, 64'd0);
    check("rst_tag", 64'(bus.out_tag), 64'd0);
    check("rst_err", 64'(bus.out_err), 64'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    tick();

    single("e32_mul", mk(2, 0, 64'h00000007_FFFFFFFD, 64'h00000006_00000005,
           64'h0, 8'hFF, 4'h1), 64'h0000002A_FFFFFFF1, 1'b0);
    single("e8_mul", mk(0, 0, 64'h8080_8080_8080_8080, 64'h8080_8080_8080_8080,
           64'h0, 8'hFF, 4'h2), 64'h0, 1'b0);
    single("e8_mulh", mk(0, 1, 64'h8080_8080_8080_8080, 64'h8080_8080_8080_8080,
           64'h0, 8'hFF, 4'h3), 64'h4040_4040_4040_4040, 1'b0);
    single("e8_mulhu", mk(0, 2, 64'h8080_8080_8080_8080, 64'h8080_8080_8080_8080,
           64'h0, 8'hFF, 4'h4), 64'h4040_4040_4040_4040, 1'b0);
    single("e8_mulhsu", mk(0, 3, 64'h8080_8080_8080_8080, 64'h8080_8080_8080_8080,
           64'h0, 8'hFF, 4'h5), 64'hC0C0_C0C0_C0C0_C0C0, 1'b0);
    single("e16_mask", mk(1, 0, 64'h0100_0003_0200_0005, 64'h0100_0007_0003_0009,
           64'hAAAA_AAAA_AAAA_AAAA, 8'hFA, 4'h6), 64'h0000_AAAA_0600_AAAA, 1'b0);
    single("rsv_sew", mk(3, 1, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
           64'h12345678_9ABCDEF0, 8'hFF, 4'hB), 64'h12345678_9ABCDEF0, 1'b1);

    // Stall with a full output register, then handshake out and in together.
    bus.out_ready = 1'b0;
    drive(mk(2, 0, 64'h00000002_00000003, 64'h00000005_00000007,
             64'h0, 8'hFF, 4'h7));
    #1;
    check("stall_in_ready0", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    check_out("stall_a", 64'h0000000A_00000015, 4'h7, 1'b0);
    check("stall_in_ready1", 64'(bus.in_ready), 64'd0);
    tick();
    check_out("stall_b", 64'h0000000A_00000015, 4'h7, 1'b0);
    check("stall_in_ready2", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    drive(mk(0, 0, 64'h0303_0303_0303_0303, 64'h0505_0505_0505_0505,
             64'h0, 8'h0F, 4'h8));
    #1;
    check("both_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    check("both_bubble1", 64'(bus.out_valid), 64'd0);
    tick();
    check("both_bubble2", 64'(bus.out_valid), 64'd0);
    tick();
    check_out("both_y", 64'h00000000_0F0F0F0F, 4'h8, 1'b0);
    tick();

    stream(8, 0, "b2b");
    stream(60, 1, "rand");

    // Reset with three ops in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(mk(2, 0, 64'h00000009_00000009, 64'h00000009_00000009,
               64'h0, 8'hFF, 4'(9 + i)));
      tick();
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("midrst_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_data", bus.out_data, 64'd0);
    check("midrst_tag", 64'(bus.out_tag), 64'd0);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (5) begin
      tick();
      check("midrst_stale", 64'(bus.out_valid), 64'd0);
    end
    single("post_rst", mk(1, 2, 64'hFFFE_FFFE_FFFE_FFFE, 64'h0003_0003_0003_0003,
           64'h0, 8'hFF, 4'hC), 64'h0002_0002_0002_0002, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
